// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int DMEM_DEPTH = 64;
  localparam int WORD_W     = 32;

  // Arbitration priority state: who wins when both sides request.
  typedef enum logic {
    CPU_PRI   = 1'b0,
    DMA_FORCE = 1'b1
  } arb_state_t;

  // Requester indices into the per-side request vectors.
  localparam int REQ_CPU = 0;
  localparam int REQ_DMA = 1;

endpackage

// File: rtl/dmem_rsp_reg.sv
// Per-requester response stage: registers completion, read data and range error.
// Latency: 1 cycle after the grant; rdata is forced to 0 for writes and out-of-range.
// Backpressure: none; a response is a single-cycle pulse the requester must take.
// Ports: gnt/we/oor describe this cycle's access, mem_rdata is the combinational
//        memory read; rvalid/rdata/err are the registered results.
module dmem_rsp_reg
  import dmem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt,
  input  logic              we,
  input  logic              oor,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [WORD_W-1:0] rdata,
  output logic              err
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= gnt;
      err    <= gnt & oor;
      // Only an in-range read returns memory contents; everything else reads as 0.
      rdata  <= (gnt && !we && !oor) ? mem_rdata : '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and a DMA loader.
// Latency: grant and memory access in the request cycle, response one cycle later.
// Backpressure: the loser keeps its request held; the CPU sees cpu_stall, and DMA
//               is forced through after MAX_WAIT consecutive waiting cycles.
// Ports: cpu_* and dma_* request/response sets, mem_* drive the memory,
//        mem_rdata is its combinational read data.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH    = DMEM_DEPTH,
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [WORD_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_err,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [WORD_W-1:0] dma_addr,
  input  logic [WORD_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [WORD_W-1:0] dma_rdata,
  output logic              dma_err,
  output logic              mem_we,
  output logic [WORD_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata
);

  localparam logic [WORD_W-1:0] DEPTH_W = WORD_W'(DEPTH);
  localparam logic [CNT_W-1:0]  MAX_W   = CNT_W'(MAX_WAIT);

  arb_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             dma_wait;

  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  oor;
  logic [1:0]  gnt;

  assign req[REQ_CPU] = cpu_req;
  assign req[REQ_DMA] = dma_req;
  assign we[REQ_CPU]  = cpu_we;
  assign we[REQ_DMA]  = dma_we;
  // Full 32-bit compare so wrapped addresses like 0xFFFFFFFF are still rejected.
  assign oor[REQ_CPU] = (cpu_addr >= DEPTH_W);
  assign oor[REQ_DMA] = (dma_addr >= DEPTH_W);

  // Grants are held off during reset so nothing reaches memory while rst_n is low.
  always_comb begin
    gnt = '0;
    if (rst_n) begin
      if (req[REQ_DMA] && (!req[REQ_CPU] || state == DMA_FORCE)) begin
        gnt[REQ_DMA] = 1'b1;
      end else if (req[REQ_CPU]) begin
        gnt[REQ_CPU] = 1'b1;
      end
    end
  end

  assign cpu_gnt   = gnt[REQ_CPU];
  assign dma_gnt   = gnt[REQ_DMA];
  assign cpu_stall = cpu_req & ~cpu_gnt;

  // Memory-side mux; idle cycles park address and data at 0.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt[REQ_CPU]) begin
      mem_we    = we[REQ_CPU] & ~oor[REQ_CPU];
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (gnt[REQ_DMA]) begin
      mem_we    = we[REQ_DMA] & ~oor[REQ_DMA];
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // The counter tracks consecutive DMA waiting cycles: any cycle DMA is granted or
  // not requesting breaks the streak and clears it.
  assign dma_wait = req[REQ_DMA] & ~gnt[REQ_DMA];

  always_comb begin
    wait_cnt_nxt = '0;
    if (dma_wait) begin
      wait_cnt_nxt = (wait_cnt == MAX_W) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CPU_PRI;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt_nxt;
      if (state == CPU_PRI) begin
        if (wait_cnt_nxt == MAX_W) state <= DMA_FORCE;
      end else begin
        // One forced access, or DMA giving up, returns priority to the CPU.
        if (gnt[REQ_DMA] || !req[REQ_DMA]) state <= CPU_PRI;
      end
    end
  end

  dmem_rsp_reg u_cpu_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt[REQ_CPU]),
    .we        (we[REQ_CPU]),
    .oor       (oor[REQ_CPU]),
    .mem_rdata (mem_rdata),
    .rvalid    (cpu_rvalid),
    .rdata     (cpu_rdata),
    .err       (cpu_err)
  );

  dmem_rsp_reg u_dma_rsp (
    .clk       (clk),
    .rst_n     (rst_n),
    .gnt       (gnt[REQ_DMA]),
    .we        (we[REQ_DMA]),
    .oor       (oor[REQ_DMA]),
    .mem_rdata (mem_rdata),
    .rvalid    (dma_rvalid),
    .rdata     (dma_rdata),
    .err       (dma_err)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized and directed bench for dmem_arbiter against a behavioural model.
// Latency: model predicts grants in-cycle and responses one edge later.
// Backpressure: requesters hold requests until granted, as the CPU/DMA would.
module tb_dmem_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst_n;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, cpu_err;
  logic        dma_gnt, dma_rvalid, dma_err;
  logic [31:0] cpu_rdata, dma_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.DEPTH(64), .MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data memory attached to the arbiter; out-of-range reads return a marker value.
  logic [31:0] bmem [64];
  assign mem_rdata = (mem_addr < 32'd64) ? bmem[mem_addr[5:0]] : 32'hBAD0BAD0;
  always @(posedge clk) if (mem_we) bmem[mem_addr[5:0]] <= mem_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: memory image, DMA waiting streak, expected responses.
  logic [31:0] ref_mem [64];
  int          wait_cnt;
  logic        exp_c_rv, exp_c_err, exp_d_rv, exp_d_err;
  logic [31:0] exp_c_rd, exp_d_rd;
  logic        last_cg, last_dg;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
  endtask

  task automatic model_reset();
    wait_cnt = 0;
    exp_c_rv = 1'b0; exp_d_rv = 1'b0;
  endtask

  // One clock cycle: called just after a falling edge, returns at the next one.
  task automatic step(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd);
    logic cg, dg, exp_we;
    drive(cr, cw, ca, cd, dr, dw, da, dd);
    #1;
    // A DMA that has waited MAX_WAIT cycles in a row beats the CPU once.
    dg = dr && (!cr || wait_cnt == MAX_WAIT);
    cg = cr && !dg;
    exp_we = (cg && cw && ca < 32'd64) || (dg && dw && da < 32'd64);
    check("cpu_gnt", 32'(cpu_gnt), 32'(cg));
    check("dma_gnt", 32'(dma_gnt), 32'(dg));
    check("cpu_stall", 32'(cpu_stall), 32'(cr && !cg));
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (cg) begin
      check("mem_addr_cpu", mem_addr, ca);
      if (cw) check("mem_wdata_cpu", mem_wdata, cd);
    end else if (dg) begin
      check("mem_addr_dma", mem_addr, da);
      if (dw) check("mem_wdata_dma", mem_wdata, dd);
    end else begin
      check("mem_addr_idle", mem_addr, 32'd0);
    end
    last_cg = cg;
    last_dg = dg;
    @(posedge clk);
    exp_c_rv = cg;
    exp_d_rv = dg;
    if (cg) begin
      exp_c_err = (ca >= 32'd64);
      exp_c_rd  = (!cw && ca < 32'd64) ? ref_mem[ca[5:0]] : 32'd0;
      if (cw && ca < 32'd64) ref_mem[ca[5:0]] = cd;
    end
    if (dg) begin
      exp_d_err = (da >= 32'd64);
      exp_d_rd  = (!dw && da < 32'd64) ? ref_mem[da[5:0]] : 32'd0;
      if (dw && da < 32'd64) ref_mem[da[5:0]] = dd;
    end
    if (dr && !dg) begin
      if (wait_cnt < MAX_WAIT) wait_cnt++;
    end else begin
      wait_cnt = 0;
    end
    #1;
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_c_rv));
    check("dma_rvalid", 32'(dma_rvalid), 32'(exp_d_rv));
    if (exp_c_rv) begin
      check("cpu_rdata", cpu_rdata, exp_c_rd);
      check("cpu_err", 32'(cpu_err), 32'(exp_c_err));
    end
    if (exp_d_rv) begin
      check("dma_rdata", dma_rdata, exp_d_rd);
      check("dma_err", 32'(dma_err), 32'(exp_d_err));
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32'd64;
    if (r == 1) return 32'hFFFF_FFFF;
    if (r == 2) return $urandom | 32'h0000_0100;
    return 32'($urandom_range(0, 63));
  endfunction

  logic        pc, pcw, pd, pdw;
  logic [31:0] pca, pcd, pda, pdd;
  int          dma_cnt;
  int          first_dg;

  initial begin
    for (int i = 0; i < 64; i++) begin
      bmem[i]    = 32'h1000_0000 + 32'(i);
      ref_mem[i] = 32'h1000_0000 + 32'(i);
    end
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    model_reset();
    #2;
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    check("rst_dma_rvalid", 32'(dma_rvalid), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_err", 32'(dma_err), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle, then CPU-only write and read-back of word 5.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b1, 32'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t1_rdata", cpu_rdata, 32'hDEADBEEF);

    // Both requesting continuously: DMA takes every fifth slot.
    dma_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0, 32'($urandom_range(0, 63)), 32'd0,
           1'b1, 1'b0, 32'($urandom_range(0, 63)), 32'd0);
      check("t2_dma_slot", 32'(last_dg), 32'(i % 5 == 4));
      if (last_dg) dma_cnt++;
    end
    check("t2_dma_share", 32'(dma_cnt), 32'd4);

    // DMA write then immediate CPU read of the same word.
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd7, 32'h12345678);
    step(1'b1, 1'b0, 32'd7, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t3_rdata", cpu_rdata, 32'h12345678);

    // Out-of-range accesses: no write, error flagged, word 0 untouched.
    step(1'b1, 1'b1, 32'd64, 32'hAAAA5555, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t4_cpu_err", 32'(cpu_err), 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    check("t4_dma_err", 32'(dma_err), 32'd1);
    check("t4_dma_rdata", dma_rdata, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t4_word0", cpu_rdata, 32'h1000_0000);

    // DMA starved three cycles, drops out, then needs a full fresh wait.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
    step(1'b1, 1'b0, 32'd1, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    first_dg = -1;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0);
      if (last_dg && first_dg < 0) first_dg = i;
    end
    check("t5_first_dma", 32'(first_dg), 32'd4);

    // Reset asserted mid-cycle after a CPU read grant.
    drive(1'b1, 1'b0, 32'd5, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    #1 check("t6_gnt_before", 32'(cpu_gnt), 32'd1);
    #1 rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("t6_gnt", 32'(cpu_gnt), 32'd0);
    check("t6_mem_we", 32'(mem_we), 32'd0);
    check("t6_mem_addr", mem_addr, 32'd0);
    check("t6_mem_wdata", mem_wdata, 32'd0);
    check("t6_rvalid_now", 32'(cpu_rvalid), 32'd0);
    check("t6_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    check("t6_rvalid_edge", 32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Reset while a CPU write is being requested: the write must not land.
    drive(1'b1, 1'b1, 32'd9, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0, 32'd0);
    #2 rst_n = 1'b0;
    #1 check("t6w_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;
    check("t6w_rvalid", 32'(cpu_rvalid), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0, 32'd9, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    check("t6w_word9", cpu_rdata, 32'h1000_0009);

    // Random traffic with requests held until granted.
    pc = 1'b0; pd = 1'b0;
    pcw = 1'b0; pdw = 1'b0;
    pca = '0; pcd = '0; pda = '0; pdd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pc && $urandom_range(0, 99) < 60) begin
        pc = 1'b1; pcw = 1'($urandom_range(0, 1)); pca = rand_addr(); pcd = $urandom;
      end
      if (pd && $urandom_range(0, 99) < 5) pd = 1'b0;
      else if (!pd && $urandom_range(0, 99) < 60) begin
        pd = 1'b1; pdw = 1'($urandom_range(0, 1)); pda = rand_addr(); pdd = $urandom;
      end
      step(pc, pcw, pca, pcd, pd, pdw, pda, pdd);
      if (last_cg) pc = 1'b0;
      if (last_dg) pd = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
